// File: rtl/decode_cycle.sv
// Decode stage: RV32I-subset decoder, 32x32 register file and execute-stage register.
// Build option: define DECODE_WB_BYPASS_EN for write-first forwarding from writeback.
module decode_cycle (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr_d,
   input  logic [31:0] pc_d,
   input  logic [31:0] pcplus4_d,
   input  logic        flush_e,
   input  logic        regwrite_w,
   input  logic [4:0]  rd_w,
   input  logic [31:0] result_w,
   output logic [4:0]  rs1_d,
   output logic [4:0]  rs2_d,
   output logic        regwrite_e,
   output logic [1:0]  resultsrc_e,
   output logic        memwrite_e,
   output logic        jump_e,
   output logic        branch_e,
   output logic        alusrc_e,
   output logic [2:0]  alucontrol_e,
   output logic [31:0] rd1_e,
   output logic [31:0] rd2_e,
   output logic [31:0] imm_ext_e,
   output logic [31:0] pc_e,
   output logic [31:0] pcplus4_e,
   output logic [4:0]  rs1_e,
   output logic [4:0]  rs2_e,
   output logic [4:0]  rd_e,
   output logic        illegal_e
);

   typedef enum logic [2:0] {
      IMM_Z, IMM_I, IMM_S, IMM_B, IMM_J
   } immsrc_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   logic [31:0] regs [32];
   logic [6:0]  op;
   logic [2:0]  f3;
   logic [31:0] rd1, rd2, imm;
   logic        c_regwrite, c_memwrite, c_jump, c_branch, c_alusrc;
   logic [1:0]  c_resultsrc;
   logic [2:0]  c_alu;
   immsrc_t     immsrc;
   logic        legal, is_alu, is_r, bubble, illegal;

   assign op    = instr_d[6:0];
   assign f3    = instr_d[14:12];
   assign rs1_d = instr_d[19:15];
   assign rs2_d = instr_d[24:20];

   always_comb begin
      rd1 = (rs1_d == 5'd0) ? 32'd0 : regs[rs1_d];
      rd2 = (rs2_d == 5'd0) ? 32'd0 : regs[rs2_d];
`ifdef DECODE_WB_BYPASS_EN
      if (regwrite_w && rd_w != 5'd0 && rd_w == rs1_d) rd1 = result_w;
      if (regwrite_w && rd_w != 5'd0 && rd_w == rs2_d) rd2 = result_w;
`endif
   end

   always_comb begin
      c_regwrite  = 1'b0;
      c_resultsrc = 2'b00;
      c_memwrite  = 1'b0;
      c_jump      = 1'b0;
      c_branch    = 1'b0;
      c_alusrc    = 1'b0;
      c_alu       = ALU_ADD;
      immsrc      = IMM_Z;
      legal       = 1'b1;
      is_alu      = 1'b0;
      is_r        = 1'b0;
      case (op)
         7'b0000011: begin
            c_regwrite = 1'b1; c_resultsrc = 2'b01;
            c_alusrc = 1'b1; immsrc = IMM_I;
            legal = (f3 == 3'b010);
         end
         7'b0100011: begin
            c_memwrite = 1'b1; c_alusrc = 1'b1; immsrc = IMM_S;
            legal = (f3 == 3'b010);
         end
         7'b0110011: begin
            c_regwrite = 1'b1; is_alu = 1'b1; is_r = 1'b1;
         end
         7'b0010011: begin
            c_regwrite = 1'b1; c_alusrc = 1'b1;
            immsrc = IMM_I; is_alu = 1'b1;
         end
         7'b1100011: begin
            c_branch = 1'b1; c_alu = ALU_SUB; immsrc = IMM_B;
            legal = (f3 == 3'b000);
         end
         7'b1101111: begin
            c_regwrite = 1'b1; c_resultsrc = 2'b10;
            c_jump = 1'b1; immsrc = IMM_J;
         end
         default: legal = 1'b0;
      endcase
      // funct7[5] only distinguishes sub for register-register ops
      if (is_alu) begin
         case (f3)
            3'b000:  c_alu = (is_r && instr_d[30]) ? ALU_SUB : ALU_ADD;
            3'b010:  c_alu = ALU_SLT;
            3'b110:  c_alu = ALU_OR;
            3'b111:  c_alu = ALU_AND;
            default: legal = 1'b0;
         endcase
      end
   end

   always_comb begin
      case (immsrc)
         IMM_I:   imm = {{20{instr_d[31]}}, instr_d[31:20]};
         IMM_S:   imm = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
         IMM_B:   imm = {{20{instr_d[31]}}, instr_d[7], instr_d[30:25],
                         instr_d[11:8], 1'b0};
         IMM_J:   imm = {{12{instr_d[31]}}, instr_d[19:12], instr_d[20],
                         instr_d[30:21], 1'b0};
         default: imm = 32'd0;
      endcase
   end

   assign bubble  = !legal || (instr_d == 32'd0);
   assign illegal = !legal && (instr_d != 32'd0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      end else if (regwrite_w && rd_w != 5'd0) begin
         regs[rd_w] <= result_w;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst || flush_e) begin
         regwrite_e   <= 1'b0;
         resultsrc_e  <= 2'b00;
         memwrite_e   <= 1'b0;
         jump_e       <= 1'b0;
         branch_e     <= 1'b0;
         alusrc_e     <= 1'b0;
         alucontrol_e <= 3'b000;
         rd1_e        <= 32'd0;
         rd2_e        <= 32'd0;
         imm_ext_e    <= 32'd0;
         pc_e         <= 32'd0;
         pcplus4_e    <= 32'd0;
         rs1_e        <= 5'd0;
         rs2_e        <= 5'd0;
         rd_e         <= 5'd0;
         illegal_e    <= 1'b0;
      end else begin
         rd1_e     <= rd1;
         rd2_e     <= rd2;
         imm_ext_e <= imm;
         pc_e      <= pc_d;
         pcplus4_e <= pcplus4_d;
         illegal_e <= illegal;
         if (bubble) begin
            regwrite_e   <= 1'b0;
            resultsrc_e  <= 2'b00;
            memwrite_e   <= 1'b0;
            jump_e       <= 1'b0;
            branch_e     <= 1'b0;
            alusrc_e     <= 1'b0;
            alucontrol_e <= 3'b000;
            rs1_e        <= 5'd0;
            rs2_e        <= 5'd0;
            rd_e         <= 5'd0;
         end else begin
            regwrite_e   <= c_regwrite;
            resultsrc_e  <= c_resultsrc;
            memwrite_e   <= c_memwrite;
            jump_e       <= c_jump;
            branch_e     <= c_branch;
            alusrc_e     <= c_alusrc;
            alucontrol_e <= c_alu;
            rs1_e        <= rs1_d;
            rs2_e        <= rs2_d;
            rd_e         <= instr_d[11:7];
         end
      end
   end

endmodule

// File: tb/tb_decode_cycle.sv
// Randomized bench for decode_cycle against an instruction-level reference model.
module tb_decode_cycle;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, flush_e, regwrite_w;
   logic [31:0] instr_d, pc_d, pcplus4_d, result_w;
   logic [4:0]  rd_w;
   logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
   logic        regwrite_e, memwrite_e, jump_e, branch_e, alusrc_e, illegal_e;
   logic [1:0]  resultsrc_e;
   logic [2:0]  alucontrol_e;
   logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pcplus4_e;

   decode_cycle dut (
      .clk(clk), .rst(rst), .instr_d(instr_d), .pc_d(pc_d),
      .pcplus4_d(pcplus4_d), .flush_e(flush_e), .regwrite_w(regwrite_w),
      .rd_w(rd_w), .result_w(result_w), .rs1_d(rs1_d), .rs2_d(rs2_d),
      .regwrite_e(regwrite_e), .resultsrc_e(resultsrc_e),
      .memwrite_e(memwrite_e), .jump_e(jump_e), .branch_e(branch_e),
      .alusrc_e(alusrc_e), .alucontrol_e(alucontrol_e), .rd1_e(rd1_e),
      .rd2_e(rd2_e), .imm_ext_e(imm_ext_e), .pc_e(pc_e),
      .pcplus4_e(pcplus4_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
      .illegal_e(illegal_e)
   );

   typedef struct {
      logic [7:0]  ctrl;
      logic [2:0]  alu;
      logic [31:0] rd1, rd2, imm, pc, pc4;
      logic [4:0]  rs1, rs2, rd;
      logic        illegal;
      logic        imm_known;
   } exp_t;

   int checks = 0;
   int errors = 0;
   logic [31:0] mreg [32];

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h (t=%0t)", n, act, req, $time);
      end
   endtask

   function automatic logic [31:0] rf(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
      if (regwrite_w && rd_w == a) return result_w;
`endif
      return mreg[a];
   endfunction

   // ctrl = {regwrite, resultsrc[1:0], memwrite, jump, branch, alusrc, 0}
   function automatic exp_t model();
      exp_t e;
      logic [31:0] i;
      logic [2:0] f3;
      logic ok;
      int s12, s13, s21;
      i = instr_d;
      f3 = i[14:12];
      e = '{ctrl: '0, alu: '0, rd1: '0, rd2: '0, imm: '0, pc: '0,
             pc4: '0, rs1: '0, rs2: '0, rd: '0, illegal: 1'b0,
             imm_known: 1'b1};
      if (!rst || flush_e) return e;
      e.pc  = pc_d;
      e.pc4 = pcplus4_d;
      e.rd1 = rf(i[19:15]);
      e.rd2 = rf(i[24:20]);
      s12 = $signed(i[31:20]);
      ok = 1'b1;
      case (i[6:0])
         7'b0000011: begin
            e.ctrl = 8'b1_01_0_0_0_1_0; e.imm = s12; ok = (f3 == 3'd2);
         end
         7'b0100011: begin
            e.ctrl = 8'b0_00_1_0_0_1_0; ok = (f3 == 3'd2);
            s12 = $signed({i[31:25], i[11:7]}); e.imm = s12;
         end
         7'b1100011: begin
            e.ctrl = 8'b0_00_0_0_1_0_0; e.alu = 3'b001; ok = (f3 == 3'd0);
            s13 = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
            e.imm = s13;
         end
         7'b1101111: begin
            e.ctrl = 8'b1_10_0_1_0_0_0;
            s21 = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
            e.imm = s21;
         end
         7'b0110011, 7'b0010011: begin
            if (i[6:0] == 7'b0110011) e.ctrl = 8'b1_00_0_0_0_0_0;
            else begin e.ctrl = 8'b1_00_0_0_0_1_0; e.imm = s12; end
            case (f3)
               3'd0: e.alu = (i[6:0] == 7'b0110011 && i[30]) ? 3'b001 : 3'b000;
               3'd2: e.alu = 3'b101;
               3'd6: e.alu = 3'b011;
               3'd7: e.alu = 3'b010;
               default: ok = 1'b0;
            endcase
         end
         default: begin ok = 1'b0; e.imm_known = 1'b0; end
      endcase
      if (!ok || i == 32'd0) begin
         e.ctrl = '0;
         e.alu = '0;
         e.illegal = (i != 32'd0);
      end else begin
         e.rs1 = i[19:15];
         e.rs2 = i[24:20];
         e.rd  = i[11:7];
      end
      return e;
   endfunction

   task automatic step();
      exp_t e;
      #1;
      chk("rs1_d", rs1_d, instr_d[19:15]);
      chk("rs2_d", rs2_d, instr_d[24:20]);
      e = model();
      @(posedge clk);
      if (!rst) begin
         for (int k = 0; k < 32; k++) mreg[k] = 32'd0;
      end else if (regwrite_w && rd_w != 5'd0) begin
         mreg[rd_w] = result_w;
      end
      #1;
      chk("ctrl", {regwrite_e, resultsrc_e, memwrite_e, jump_e, branch_e,
                   alusrc_e, 1'b0}, e.ctrl);
      chk("alucontrol_e", alucontrol_e, e.alu);
      chk("rd1_e", rd1_e, e.rd1);
      chk("rd2_e", rd2_e, e.rd2);
      if (e.imm_known) chk("imm_ext_e", imm_ext_e, e.imm);
      chk("pc_e", pc_e, e.pc);
      chk("pcplus4_e", pcplus4_e, e.pc4);
      chk("rs1_e", rs1_e, e.rs1);
      chk("rs2_e", rs2_e, e.rs2);
      chk("rd_e", rd_e, e.rd);
      chk("illegal_e", illegal_e, e.illegal);
   endtask

   task automatic drive(input logic [31:0] ins, input logic fl,
                        input logic we, input logic [4:0] wa,
                        input logic [31:0] wd);
      instr_d = ins;
      flush_e = fl;
      regwrite_w = we;
      rd_w = wa;
      result_w = wd;
      pc_d = $urandom;
      pcplus4_d = pc_d + 32'd4;
      step();
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] i;
      int k;
      i = $urandom;
      k = $urandom_range(0, 7);
      case (k)
         0: i[6:0] = 7'b0000011;
         1: i[6:0] = 7'b0100011;
         2: i[6:0] = 7'b0110011;
         3: i[6:0] = 7'b0010011;
         4: i[6:0] = 7'b1100011;
         5: i[6:0] = 7'b1101111;
         default: ;
      endcase
      if ($urandom_range(0, 3) != 0) begin
         case (k)
            0, 1: i[14:12] = 3'd2;
            4: i[14:12] = 3'd0;
            2, 3: begin
               k = $urandom_range(0, 3);
               i[14:12] = (k == 0) ? 3'd0 : (k == 1) ? 3'd2 : (k == 2) ? 3'd6 : 3'd7;
            end
            default: ;
         endcase
      end
      i[19:15] = 5'($urandom_range(0, 7));
      i[24:20] = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 30) == 0) i = 32'd0;
      return i;
   endfunction

   initial begin
      for (int k = 0; k < 32; k++) mreg[k] = 32'hx;
      rst = 1'b0;
      drive($urandom, $urandom, 1'b1, 5'd5, $urandom);
      drive($urandom, $urandom, 1'b1, 5'd5, $urandom);
      chk("reset regwrite_e", regwrite_e, 32'd0);
      chk("reset pc_e", pc_e, 32'd0);
      rst = 1'b1;
      drive(32'h00028033, 1'b0, 1'b0, 5'd0, 32'd0);
      chk("x5 after reset", rd1_e, 32'd0);

      drive(32'h00000000, 1'b0, 1'b1, 5'd1, 32'd5);
      drive(32'h00000000, 1'b0, 1'b1, 5'd2, 32'd3);
      drive(32'h002081B3, 1'b0, 1'b0, 5'd0, 32'd0);
      chk("add rd1_e", rd1_e, 32'd5);
      chk("add rd2_e", rd2_e, 32'd3);
      chk("add alucontrol_e", alucontrol_e, 32'd0);
      chk("add regwrite_e", regwrite_e, 32'd1);
      chk("add rd_e", rd_e, 32'd3);
      drive(32'h402081B3, 1'b0, 1'b0, 5'd0, 32'd0);
      chk("sub alucontrol_e", alucontrol_e, 32'd1);

      drive(32'hFFC4A303, 1'b0, 1'b0, 5'd0, 32'd0);
      chk("lw imm_ext_e", imm_ext_e, 32'hFFFFFFFC);
      chk("lw resultsrc_e", resultsrc_e, 32'd1);
      drive(32'hFE420AE3, 1'b0, 1'b0, 5'd0, 32'd0);
      chk("beq branch_e", branch_e, 32'd1);
      chk("beq imm_ext_e", imm_ext_e, 32'hFFFFFFF4);

      drive(32'h002081B3, 1'b0, 1'b1, 5'd1, 32'hAA);
`ifdef DECODE_WB_BYPASS_EN
      chk("bypass rd1_e", rd1_e, 32'hAA);
`else
      chk("no-bypass rd1_e", rd1_e, 32'd5);
`endif
      drive(32'h00000033, 1'b0, 1'b1, 5'd0, 32'h55);
      chk("x0 same cycle", rd1_e, 32'd0);
      drive(32'h00000033, 1'b0, 1'b0, 5'd0, 32'd0);
      chk("x0 after write", rd1_e, 32'd0);

      drive(32'h002081B3, 1'b1, 1'b1, 5'd4, 32'h1234);
      chk("flush regwrite_e", regwrite_e, 32'd0);
      chk("flush rd1_e", rd1_e, 32'd0);
      drive(32'h00020033, 1'b0, 1'b0, 5'd0, 32'd0);
      chk("write during flush", rd1_e, 32'h1234);
      drive(32'h0000007F, 1'b0, 1'b0, 5'd0, 32'd0);
      chk("illegal illegal_e", illegal_e, 32'd1);
      chk("illegal regwrite_e", regwrite_e, 32'd0);
      drive(32'h00000000, 1'b0, 1'b0, 5'd0, 32'd0);
      chk("nop illegal_e", illegal_e, 32'd0);

      for (int n = 0; n < 2000; n++) begin
         rst = ($urandom_range(0, 60) != 0);
         drive(rand_instr(), ($urandom_range(0, 9) == 0),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_cycle.md
DECODE_CYCLE -- requirements
Module: decode_cycle

Interface
REQ-001 The block SHALL have no parameters; its only build option SHALL be the macro in REQ-031.
REQ-002 clk  in  1  system clock; all state SHALL update on the rising edge.
REQ-003 rst  in  1  reset, synchronous and active-low.
REQ-004 instr_d  in  32  instruction from fetch.
REQ-005 pc_d, pcplus4_d  in  32 each  PC and PC+4 of instr_d.
REQ-006 flush_e  in  1  forces a bubble into the execute register.
REQ-007 regwrite_w  in  1; rd_w  in  5; result_w  in  32  writeback port.
REQ-008 rs1_d, rs2_d  out  5 each  combinational source fields instr_d[19:15] and instr_d[24:20], for the hazard unit.
REQ-009 Registered outputs: regwrite_e 1, resultsrc_e 2, memwrite_e 1, jump_e 1, branch_e 1, alusrc_e 1, alucontrol_e 3, rd1_e 32, rd2_e 32, imm_ext_e 32, pc_e 32, pcplus4_e 32, rs1_e 5, rs2_e 5, rd_e 5, illegal_e 1.

Function
REQ-010 Latency SHALL be one cycle: the decode of instr_d at edge N SHALL appear on the *_e outputs after edge N.
REQ-011 The register file SHALL hold 32x32 bits; x0 SHALL always read 0, and writes to x0 SHALL be ignored.
REQ-012 The register file SHALL write result_w to rd_w on a rising edge when regwrite_w=1.
REQ-013 Supported opcodes, with control as {regwrite, resultsrc, memwrite, jump, branch, alusrc, immsrc}:
- lw 0000011: 1,01,0,0,0,1,I
- sw 0100011: 0,00,1,0,0,1,S
- R-type 0110011: 1,00,0,0,0,0,-
- I-ALU 0010011: 1,00,0,0,0,1,I
- beq 1100011: 0,00,0,0,1,0,B
- jal 1101111: 1,10,0,1,0,0,J
REQ-014 The ALU control encoding SHALL be: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-015 lw, sw and jal SHALL select add; beq SHALL select sub.
REQ-016 For R-type and I-ALU, funct3 SHALL select the operation: 000 add (sub if R-type and funct7[5]=1), 010 slt, 110 or, 111 and.
REQ-017 Immediates SHALL be sign-extended from instr_d[31]:
- I = instr[31:20]
- S = {instr[31:25], instr[11:7]}
- B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}
- J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- R-type imm_ext_e = 0.
REQ-018 The following SHALL be illegal: an unlisted opcode; beq with funct3≠000; lw or sw with funct3≠010; ALU funct3 outside the set in REQ-016.
REQ-019 An illegal instruction SHALL register a bubble (all control 0) with illegal_e=1.
REQ-020 instr_d=32'h00000000 SHALL register a bubble with illegal_e=0.
REQ-021 A bubble SHALL be: every control output 0, rd_e=rs1_e=rs2_e=0, illegal_e=0 unless REQ-019 applies.
REQ-022 Data fields of a bubble (rd1_e, rd2_e, imm_ext_e, pc_e, pcplus4_e) SHALL still capture their decoded values.
REQ-023 flush_e=1 SHALL register a full bubble, including illegal_e=0 and all data fields 0, regardless of instr_d.
REQ-024 A register-file write in the same cycle as flush_e SHALL still occur.
REQ-025 Priority SHALL be rst > flush_e > illegal > normal decode.

Reset
REQ-026 rst=0 at a rising edge SHALL clear every *_e output and all 32 registers to 0.
REQ-027 During reset, the writeback port SHALL be ignored.
REQ-028 Reset asserted mid-stream SHALL discard the in-flight decode; the first edge with rst=1 SHALL resume normal decode of the present instr_d.
REQ-029 rs1_d and rs2_d SHALL remain combinational and SHALL be unaffected by reset.

Configuration
REQ-030 DECODE_WB_BYPASS_EN SHALL be the single configuration macro.
REQ-031 When DECODE_WB_BYPASS_EN is defined, a read SHALL return result_w if regwrite_w=1, rd_w≠0 and rd_w equals the source register (write-first).
REQ-032 When it is undefined, a same-cycle read SHALL return the old register value; the hazard unit SHALL cover that case.

Verification
REQ-033 Reset: rst=0 for 2 edges with arbitrary inputs -> all *_e outputs 0; a subsequent read of x5 returns 0.
REQ-034 Decode: x1=5 and x2=3 preloaded via writeback; instr 0x002081B3 (add x3,x1,x2) -> rd1_e=5, rd2_e=3, alucontrol_e=000, regwrite_e=1, rd_e=3; 0x402081B3 -> alucontrol_e=001.
REQ-035 Immediates: 0xFFC4A303 (lw x6,-4(x9)) -> imm_ext_e=0xFFFFFFFC, resultsrc_e=01; 0xFE420AE3 (beq) -> branch_e=1, imm_ext_e=0xFFFFFFF4.
REQ-036 Bypass: regwrite_w=1, rd_w=1, result_w=0xAA in the same cycle that x1 is read -> rd1_e=0xAA with the macro defined, old value without it; rd_w=0 -> x0 stays 0.
REQ-037 Flush and illegal: flush_e=1 with a valid add -> all outputs 0; instr 0x0000007F -> bubble with illegal_e=1; instr 0 -> bubble with illegal_e=0.
